// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter: FSM states, grant
// encoding and bus widths.
package dmem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_P0 = 1'b0,
    GNT_P1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signal bundle for dmem_arbiter; the arbiter uses
// the slave modport, the environment (pipeline, loader, memory) the master one.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  // Requesters: req is held with its fields until the one-cycle ack; rdata is
  // valid in the ack cycle. Memory: m_req and fields stay stable until a
  // cycle in which m_ready is sampled high; m_ready is ignored while m_req=0.
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_ack;
  logic              p0_stall;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_ack;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ready;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata, p0_ack, p0_stall,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata, p1_ack,
    output m_req, m_we, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata, p0_ack, p0_stall,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata, p1_ack,
    input  m_req, m_we, m_addr, m_wdata,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Starvation counter for port 1; exists only when DMEM_ARB_STARVE_GUARD_EN
// is defined. Forces a port-1 grant after STARVE_MAX port-0 grants.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic grant_i,
  input  logic gnt_p1_i,
  input  logic p1_req_i,
  output logic force_p1_o
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // A port-0 grant while port 1 waits is the only thing that counts up.
  always_comb begin
    cnt_d = cnt_q;
    if (idle_i && !p1_req_i) begin
      cnt_d = '0;
    end else if (grant_i && gnt_p1_i) begin
      cnt_d = '0;
    end else if (grant_i && cnt_q != MAX_C) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign force_p1_o = p1_req_i && (cnt_q == MAX_C);

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 (memory stage)
// has priority; DMEM_ARB_STARVE_GUARD_EN adds a bound on port-1 waiting.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  dmem_arbiter_if.slave  mem_if,
  output state_e         dbg_state_o,
  output gnt_e           dbg_gnt_o
);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              win;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              any_req;
  logic              force_p1;

  assign any_req = mem_if.p0_req | mem_if.p1_req;
  assign win     = (force_p1 || !mem_if.p0_req) ? GNT_P1 : GNT_P0;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  dmem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .idle_i     (state_q == IDLE),
    .grant_i    ((state_q == IDLE) && any_req),
    .gnt_p1_i   (win == GNT_P1),
    .p1_req_i   (mem_if.p1_req),
    .force_p1_o (force_p1)
  );
`else
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign force_p1          = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d     = win;
          m_req_d   = 1'b1;
          m_we_d    = (win == GNT_P1) ? mem_if.p1_we    : mem_if.p0_we;
          m_addr_d  = (win == GNT_P1) ? mem_if.p1_addr  : mem_if.p0_addr;
          m_wdata_d = (win == GNT_P1) ? mem_if.p1_wdata : mem_if.p0_wdata;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (mem_if.m_ready) begin
          m_req_d = 1'b0;
          state_d = RESP;
          if (gnt_q == GNT_P1) begin
            p1_ack_d = 1'b1;
            if (!m_we_q) p1_rdata_d = mem_if.m_rdata;
          end else begin
            p0_ack_d = 1'b1;
            if (!m_we_q) p0_rdata_d = mem_if.m_rdata;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_P0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  assign mem_if.m_req    = m_req_q;
  assign mem_if.m_we     = m_we_q;
  assign mem_if.m_addr   = m_addr_q;
  assign mem_if.m_wdata  = m_wdata_q;
  assign mem_if.p0_ack   = p0_ack_q;
  assign mem_if.p1_ack   = p1_ack_q;
  assign mem_if.p0_rdata = p0_rdata_q;
  assign mem_if.p1_rdata = p1_rdata_q;
  assign mem_if.p0_stall = mem_if.p0_req & ~p0_ack_q;

  assign dbg_state_o = state_q;
  assign dbg_gnt_o   = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single accesses, delayed memory, priority,
// continuous contention (strict or guarded) and reset mid-access.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;
  gnt_e   dbg_gnt;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .STARVE_MAX (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .mem_if      (bus),
    .dbg_state_o (dbg_state),
    .dbg_gnt_o   (dbg_gnt)
  );

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          mem_delay = 0;
  int          busy_cnt  = 0;
  logic        mon_en    = 1'b0;
  logic        prev_req  = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h20:  return 32'hBAD0BAD0;
      32'h30:  return 32'h11111111;
      32'h40:  return 32'h22222222;
      default: return a ^ 32'h5A5A5A5A;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_p0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
  endtask

  task automatic drive_p1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
  endtask

  // Memory model: m_ready after mem_delay busy cycles with m_req high.
  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_req) begin
        if (busy_cnt >= mem_delay) begin
          bus.m_ready = 1'b1;
          bus.m_rdata = mem_data(bus.m_addr);
        end else begin
          bus.m_ready = 1'b0;
          bus.m_rdata = 32'hCCCCCCCC;
        end
        busy_cnt++;
      end else begin
        bus.m_ready = 1'b0;
        busy_cnt    = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && bus.m_req && !prev_req) got_q.push_back(bus.m_addr);
      prev_req = bus.m_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] g;
    rst_n = 1'b0;
    drive_p0(1'b0, 1'b0, '0, '0);
    drive_p1(1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    sample();
    check("rst_m_req",    32'(bus.m_req),    32'h0);
    check("rst_m_we",     32'(bus.m_we),     32'h0);
    check("rst_m_addr",   bus.m_addr,        32'h0);
    check("rst_m_wdata",  bus.m_wdata,       32'h0);
    check("rst_p0_ack",   32'(bus.p0_ack),   32'h0);
    check("rst_p1_ack",   32'(bus.p1_ack),   32'h0);
    check("rst_p0_rdata", bus.p0_rdata,      32'h0);
    check("rst_p1_rdata", bus.p1_rdata,      32'h0);
    check("rst_state",    32'(dbg_state),    32'(IDLE));
    check("rst_stall_lo", 32'(bus.p0_stall), 32'h0);
    bus.p0_req = 1'b1;
    #1;
    check("rst_stall_hi", 32'(bus.p0_stall), 32'h1);
    bus.p0_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Port-0 load, memory ready on the first busy cycle
    mem_delay = 0;
    next_cycle(); drive_p0(1'b1, 1'b0, 32'h10, 32'h0);
    sample();
    check("t1_c1_stall", 32'(bus.p0_stall), 32'h1);
    check("t1_c1_m_req", 32'(bus.m_req), 32'h0);
    next_cycle(); sample();
    check("t1_c2_stall", 32'(bus.p0_stall), 32'h1);
    check("t1_c2_m_req", 32'(bus.m_req), 32'h1);
    check("t1_c2_addr",  bus.m_addr, 32'h10);
    check("t1_c2_we",    32'(bus.m_we), 32'h0);
    check("t1_c2_state", 32'(dbg_state), 32'(BUSY));
    next_cycle(); sample();
    check("t1_c3_ack",   32'(bus.p0_ack), 32'h1);
    check("t1_c3_rdata", bus.p0_rdata, 32'hDEADBEEF);
    check("t1_c3_stall", 32'(bus.p0_stall), 32'h0);
    check("t1_c3_m_req", 32'(bus.m_req), 32'h0);
    next_cycle(); drive_p0(1'b0, 1'b0, '0, '0); sample();
    check("t1_c4_ack",   32'(bus.p0_ack), 32'h0);
    check("t1_c4_rdata", bus.p0_rdata, 32'hDEADBEEF);
    check("t1_c4_state", 32'(dbg_state), 32'(IDLE));
    next_cycle(); sample();
    check("t1_c5_m_req", 32'(bus.m_req), 32'h0);

    // Port-1 store, memory ready after three wait cycles
    mem_delay = 3;
    next_cycle(); drive_p1(1'b1, 1'b1, 32'h20, 32'h12345678); sample();
    check("t2_c1_ack", 32'(bus.p1_ack), 32'h0);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); sample();
      check("t2_busy_m_req", 32'(bus.m_req), 32'h1);
      check("t2_busy_we",    32'(bus.m_we), 32'h1);
      check("t2_busy_addr",  bus.m_addr, 32'h20);
      check("t2_busy_wdata", bus.m_wdata, 32'h12345678);
      check("t2_busy_ack",   32'(bus.p1_ack), 32'h0);
    end
    next_cycle(); sample();
    check("t2_ack",     32'(bus.p1_ack), 32'h1);
    check("t2_rdata",   bus.p1_rdata, 32'h0);
    check("t2_p0_ack",  32'(bus.p0_ack), 32'h0);
    check("t2_m_req",   32'(bus.m_req), 32'h0);
    next_cycle(); drive_p1(1'b0, 1'b0, '0, '0); sample();
    check("t2_ack_off", 32'(bus.p1_ack), 32'h0);

    // Simultaneous requests: port 0 first, port 1 after port 0's RESP
    mem_delay = 0;
    next_cycle();
    drive_p0(1'b1, 1'b0, 32'h30, 32'h0);
    drive_p1(1'b1, 1'b0, 32'h40, 32'h0);
    sample();
    next_cycle(); sample();
    check("t3_c2_addr", bus.m_addr, 32'h30);
    check("t3_c2_gnt",  32'(dbg_gnt), 32'(GNT_P0));
    next_cycle(); sample();
    check("t3_c3_p0_ack", 32'(bus.p0_ack), 32'h1);
    check("t3_c3_p0_rd",  bus.p0_rdata, 32'h11111111);
    check("t3_c3_p1_ack", 32'(bus.p1_ack), 32'h0);
    next_cycle(); drive_p0(1'b0, 1'b0, '0, '0); sample();
    check("t3_c4_m_req", 32'(bus.m_req), 32'h0);
    check("t3_c4_state", 32'(dbg_state), 32'(IDLE));
    next_cycle(); sample();
    check("t3_c5_m_req", 32'(bus.m_req), 32'h1);
    check("t3_c5_addr",  bus.m_addr, 32'h40);
    check("t3_c5_gnt",   32'(dbg_gnt), 32'(GNT_P1));
    next_cycle(); sample();
    check("t3_c6_p1_ack", 32'(bus.p1_ack), 32'h1);
    check("t3_c6_p1_rd",  bus.p1_rdata, 32'h22222222);
    check("t3_c6_p0_rd",  bus.p0_rdata, 32'h11111111);
    next_cycle(); drive_p1(1'b0, 1'b0, '0, '0);

    // Both ports requesting continuously: six grants
`ifdef DMEM_ARB_STARVE_GUARD_EN
    exp_q = '{32'h50, 32'h50, 32'h60, 32'h50, 32'h50, 32'h60};
`else
    exp_q = '{32'h50, 32'h50, 32'h50, 32'h50, 32'h50, 32'h50};
`endif
    got_q.delete();
    next_cycle();
    mon_en = 1'b1;
    drive_p0(1'b1, 1'b0, 32'h50, 32'h0);
    drive_p1(1'b1, 1'b0, 32'h60, 32'h0);
    repeat (18) next_cycle();
    drive_p0(1'b0, 1'b0, '0, '0);
    drive_p1(1'b0, 1'b0, '0, '0);
    repeat (4) next_cycle();
    mon_en = 1'b0;
    check("t4_grant_count", 32'(got_q.size()), 32'd6);
    while (exp_q.size() > 0) begin
      if (got_q.size() > 0) g = got_q.pop_front();
      else g = 32'hFFFFFFFF;
      check("t4_grant_order", g, exp_q.pop_front());
    end

    // Reset while busy with the memory stalled
    mem_delay = 100;
    next_cycle(); drive_p0(1'b1, 1'b0, 32'h70, 32'h0);
    next_cycle(); next_cycle(); sample();
    check("t5_busy_m_req", 32'(bus.m_req), 32'h1);
    check("t5_busy_state", 32'(dbg_state), 32'(BUSY));
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_m_req",    32'(bus.m_req), 32'h0);
    check("t5_rst_m_addr",   bus.m_addr, 32'h0);
    check("t5_rst_m_we",     32'(bus.m_we), 32'h0);
    check("t5_rst_m_wdata",  bus.m_wdata, 32'h0);
    check("t5_rst_p0_ack",   32'(bus.p0_ack), 32'h0);
    check("t5_rst_p1_ack",   32'(bus.p1_ack), 32'h0);
    check("t5_rst_p0_rdata", bus.p0_rdata, 32'h0);
    check("t5_rst_p1_rdata", bus.p1_rdata, 32'h0);
    check("t5_rst_state",    32'(dbg_state), 32'(IDLE));
    drive_p0(1'b0, 1'b0, '0, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mem_delay = 0;
    sample();
    check("t5_no_ack", 32'(bus.p0_ack), 32'h0);
    next_cycle(); drive_p0(1'b1, 1'b0, 32'h10, 32'h0);
    next_cycle(); next_cycle(); sample();
    check("t5_fresh_ack",   32'(bus.p0_ack), 32'h1);
    check("t5_fresh_rdata", bus.p0_rdata, 32'hDEADBEEF);
    next_cycle(); drive_p0(1'b0, 1'b0, '0, '0);
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
